gcount_ctrl: RTL and testbench

Sequencer for the 32-bit gated counter datapath (gcounter) used in the power handout experiments. It accepts a run command carrying a count length. It clears the counter, then enables counting for exactly that many cycles, pulses done, and checks the counter's q against the expected value. An optional idle clock-gate controller shuts off the counter clock when no work is pending.

---
 rtl/gcount_pkg.sv | 15 +
 rtl/gcount_ctrl_if.sv | 30 +++
 rtl/gcount_idle_gate.sv | 62 ++++++
 rtl/gcount_ctrl.sv | 122 ++++++++++++
 tb/tb_gcount_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcount_pkg.sv
// Shared types and constants for the gcounter sequencer.
// The GATED/WAKE states are only reached when GCTRL_IDLE_GATE_EN is defined.
package gcount_pkg;
  localparam int unsigned GC_W       = 32;
  localparam int unsigned IDLE_CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    GATED = 3'd4,
    WAKE  = 3'd5
  } state_e;
endpackage

// File: rtl/gcount_ctrl_if.sv
// Command, datapath and status bundle between a requester/gcounter and gcount_ctrl.
// Handshake: a command transfers on a rising clk edge where cmd_valid && cmd_ready;
// the requester holds cmd_valid/cmd_len stable until then, and cmd_ready never depends on cmd_valid.
interface gcount_ctrl_if import gcount_pkg::*; #(
  parameter int unsigned W = GC_W
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic [W-1:0] cmd_len;
  logic         abort;
  logic [W-1:0] q;
  logic         cnt_clr;
  logic         cnt_en;
  logic         gclk_en;
  logic         busy;
  logic         done;
  logic         mismatch;
  logic         aborted;
  state_e       dbg_state;

  modport master (
    output cmd_valid, cmd_len, abort, q,
    input  cmd_ready, cnt_clr, cnt_en, gclk_en, busy, done, mismatch, aborted, dbg_state
  );

  modport slave (
    input  cmd_valid, cmd_len, abort, q,
    output cmd_ready, cnt_clr, cnt_en, gclk_en, busy, done, mismatch, aborted, dbg_state
  );
endinterface

// File: rtl/gcount_idle_gate.sv
// Idle clock-gate controller: closes the counter clock after IDLE_TIMEOUT quiet IDLE cycles
// and holds it open WAKE_CYC cycles after a request before letting commands through.
module gcount_idle_gate import gcount_pkg::*; #(
  parameter int unsigned IDLE_TIMEOUT = 8,
  parameter int unsigned WAKE_CYC     = 2
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   ctrl_idle_i,
  input  logic   cmd_valid_i,
  output logic   gclk_en_o,
  output logic   gate_ready_o,
  output state_e gate_state_o
);
  localparam logic [IDLE_CNT_W-1:0] TIMEOUT_M1 = IDLE_CNT_W'(IDLE_TIMEOUT - 1);
  localparam logic [IDLE_CNT_W-1:0] WAKE_M1    = IDLE_CNT_W'(WAKE_CYC - 1);

  state_e                g_state_q, g_state_d;
  logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [IDLE_CNT_W-1:0] wake_cnt_q, wake_cnt_d;
  logic                  gclk_en_q, ready_q;

  always_comb begin
    g_state_d  = g_state_q;
    idle_cnt_d = '0;
    wake_cnt_d = '0;
    case (g_state_q)
      IDLE: begin
        if (ctrl_idle_i && !cmd_valid_i) begin
          if (idle_cnt_q == TIMEOUT_M1) g_state_d = GATED;
          else                          idle_cnt_d = idle_cnt_q + 1'b1;
        end
      end
      GATED: if (cmd_valid_i) g_state_d = WAKE;
      WAKE: begin
        if (wake_cnt_q == WAKE_M1) g_state_d = IDLE;
        else                       wake_cnt_d = wake_cnt_q + 1'b1;
      end
      default: g_state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      g_state_q  <= IDLE;
      idle_cnt_q <= '0;
      wake_cnt_q <= '0;
      gclk_en_q  <= 1'b1;
      ready_q    <= 1'b1;
    end else begin
      g_state_q  <= g_state_d;
      idle_cnt_q <= idle_cnt_d;
      wake_cnt_q <= wake_cnt_d;
      gclk_en_q  <= (g_state_d != GATED);
      ready_q    <= (g_state_d == IDLE);
    end
  end

  assign gclk_en_o    = gclk_en_q;
  assign gate_ready_o = ready_q;
  assign gate_state_o = g_state_q;
endmodule

// File: rtl/gcount_ctrl.sv
// Run sequencer for the gated counter: clear, count exactly cmd_len cycles, pulse done, check q.
// Define GCTRL_IDLE_GATE_EN to add the idle clock-gate controller (gcount_idle_gate).
module gcount_ctrl import gcount_pkg::*; #(
  parameter int unsigned W = GC_W
`ifdef GCTRL_IDLE_GATE_EN
  , parameter int unsigned IDLE_TIMEOUT = 8
  , parameter int unsigned WAKE_CYC     = 2
`endif
) (
  input logic         clk,
  input logic         reset,
  gcount_ctrl_if.slave bus
);
  state_e       state_q, state_d;
  logic [W-1:0] len_q, len_d;
  logic [W-1:0] rem_q, rem_d;
  logic         cmd_ready_q, cnt_clr_q, cnt_en_q, busy_q, done_q, aborted_q, chk_q;
  logic         aborted_d, chk_d;
  logic         gate_ready;
  logic         accept;

  assign accept = bus.cmd_valid && bus.cmd_ready;

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    rem_d     = rem_q;
    aborted_d = 1'b0;
    chk_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          len_d   = bus.cmd_len;
          rem_d   = bus.cmd_len;
          state_d = (bus.cmd_len == '0) ? DONE : CLEAR;
        end
      end
      CLEAR: begin
        if (bus.abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        rem_d = rem_q - W'(1);
        // abort wins over the natural end of the run
        if (bus.abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end else if (rem_q == W'(1)) begin
          state_d = DONE;
          chk_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      rem_q       <= '0;
      cmd_ready_q <= 1'b1;
      cnt_clr_q   <= 1'b0;
      cnt_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      chk_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      cmd_ready_q <= (state_d == IDLE);
      cnt_clr_q   <= (state_d == CLEAR);
      cnt_en_q    <= (state_d == RUN);
      busy_q      <= (state_d == CLEAR) || (state_d == RUN);
      done_q      <= (state_d == DONE);
      aborted_q   <= aborted_d;
      chk_q       <= chk_d;
    end
  end

  // q settles on the edge that enters DONE, so it is compared during the DONE cycle itself;
  // chk_q is only set for completed runs, keeping zero-length and aborted runs at mismatch=0.
  assign bus.mismatch  = chk_q && (bus.q != len_q);
  assign bus.cmd_ready = cmd_ready_q && gate_ready;
  assign bus.cnt_clr   = cnt_clr_q;
  assign bus.cnt_en    = cnt_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.aborted   = aborted_q;

`ifdef GCTRL_IDLE_GATE_EN
  state_e gate_state;
  logic   gclk_en;

  gcount_idle_gate #(
    .IDLE_TIMEOUT (IDLE_TIMEOUT),
    .WAKE_CYC     (WAKE_CYC)
  ) u_idle_gate (
    .clk          (clk),
    .reset        (reset),
    .ctrl_idle_i  (state_q == IDLE),
    .cmd_valid_i  (bus.cmd_valid),
    .gclk_en_o    (gclk_en),
    .gate_ready_o (gate_ready),
    .gate_state_o (gate_state)
  );

  assign bus.gclk_en   = gclk_en;
  assign bus.dbg_state = (state_q == IDLE) ? gate_state : state_q;
`else
  assign gate_ready    = 1'b1;
  assign bus.gclk_en   = 1'b1;
  assign bus.dbg_state = state_q;
`endif
endmodule

// File: tb/tb_gcount_ctrl.sv
// Directed bench for gcount_ctrl with a behavioural gcounter model on q.
// The idle-gate scenario is built only when GCTRL_IDLE_GATE_EN is defined.
module tb_gcount_ctrl;
  import gcount_pkg::*;

  logic        clk;
  logic        reset;
  int          tests;
  int          fails;
  logic [31:0] model_q;
  logic        skip_req;
  logic        skip_done;

  gcount_ctrl_if #(.W(32)) gc_if ();

  gcount_ctrl #(.W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gc_if.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // gcounter model; skip_req drops exactly one increment
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_q   <= '0;
      skip_done <= 1'b0;
    end else begin
      if (!skip_req) skip_done <= 1'b0;
      if (gc_if.gclk_en) begin
        if (gc_if.cnt_clr) model_q <= '0;
        else if (gc_if.cnt_en) begin
          if (skip_req && !skip_done) skip_done <= 1'b1;
          else                        model_q <= model_q + 32'd1;
        end
      end
    end
  end
  assign gc_if.q = model_q;

  // driver: called at a negedge, returns at the negedge of cycle 1 after the handshake
  task automatic issue(input logic [31:0] len, output bit ok);
    ok = 1'b0;
    gc_if.cmd_valid = 1'b1;
    gc_if.cmd_len   = len;
    for (int i = 0; i < 40; i++) begin
      if (gc_if.cmd_ready === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    gc_if.cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    gc_if.cmd_valid = 1'b0;
    gc_if.cmd_len   = '0;
    gc_if.abort     = 1'b0;
    skip_req        = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({gc_if.cmd_ready, gc_if.cnt_clr, gc_if.cnt_en, gc_if.busy, gc_if.done,
         gc_if.mismatch, gc_if.aborted, gc_if.gclk_en} !== 8'b1000_0001) begin
      fails++;
      $display("FAIL reset_outputs: got rdy,clr,en,busy,done,mis,abt,gclk=%b required 10000001",
               {gc_if.cmd_ready, gc_if.cnt_clr, gc_if.cnt_en, gc_if.busy, gc_if.done,
                gc_if.mismatch, gc_if.aborted, gc_if.gclk_en});
    end
  endtask

  task automatic test_run_len5();
    bit       ok;
    logic [4:0] exp_v;
    issue(32'd5, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL len5_accept: got no handshake required accept"); end
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) @(negedge clk);
      exp_v = {c == 1, c >= 2 && c <= 6, c >= 1 && c <= 6, c == 7, c == 8};
      tests++;
      if ({gc_if.cnt_clr, gc_if.cnt_en, gc_if.busy, gc_if.done, gc_if.cmd_ready} !== exp_v) begin
        fails++;
        $display("FAIL len5_cycle%0d: got clr,en,busy,done,rdy=%b required %b", c,
                 {gc_if.cnt_clr, gc_if.cnt_en, gc_if.busy, gc_if.done, gc_if.cmd_ready}, exp_v);
      end
      if (c == 7) begin
        tests++;
        if ({gc_if.q, gc_if.mismatch, gc_if.aborted} !== {32'd5, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL len5_result: got q=%0d mis=%b abt=%b required q=5 mis=0 abt=0",
                   gc_if.q, gc_if.mismatch, gc_if.aborted);
        end
      end
    end
  endtask

  task automatic test_zero_len();
    bit ok;
    issue(32'd0, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL len0_accept: got no handshake required accept"); end
    tests++;
    if ({gc_if.done, gc_if.cnt_clr, gc_if.cnt_en, gc_if.busy, gc_if.mismatch, gc_if.cmd_ready} !== 6'b100000) begin
      fails++;
      $display("FAIL len0_done: got done,clr,en,busy,mis,rdy=%b required 100000",
               {gc_if.done, gc_if.cnt_clr, gc_if.cnt_en, gc_if.busy, gc_if.mismatch, gc_if.cmd_ready});
    end
    @(negedge clk);
    tests++;
    if ({gc_if.done, gc_if.cnt_clr, gc_if.cnt_en, gc_if.cmd_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL len0_after: got done,clr,en,rdy=%b required 0001",
               {gc_if.done, gc_if.cnt_clr, gc_if.cnt_en, gc_if.cmd_ready});
    end
  endtask

  task automatic test_abort();
    bit         ok;
    int         en_cnt;
    logic [3:0] exp_v;
    en_cnt = 0;
    issue(32'd1000, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL abort_accept: got no handshake required accept"); end
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) @(negedge clk);
      if (gc_if.cnt_en === 1'b1) en_cnt++;
      exp_v = {c >= 2 && c <= 5, c <= 5, c == 6, c == 7};
      tests++;
      if ({gc_if.cnt_en, gc_if.busy, gc_if.done, gc_if.cmd_ready} !== exp_v) begin
        fails++;
        $display("FAIL abort_cycle%0d: got en,busy,done,rdy=%b required %b", c,
                 {gc_if.cnt_en, gc_if.busy, gc_if.done, gc_if.cmd_ready}, exp_v);
      end
      if (c == 6) begin
        tests++;
        if ({gc_if.aborted, gc_if.mismatch, gc_if.q} !== {1'b1, 1'b0, 32'd4}) begin
          fails++;
          $display("FAIL abort_result: got abt=%b mis=%b q=%0d required abt=1 mis=0 q=4",
                   gc_if.aborted, gc_if.mismatch, gc_if.q);
        end
      end
      if (c == 5) gc_if.abort = 1'b1;
      if (c == 6) gc_if.abort = 1'b0;
    end
    tests++;
    if (en_cnt != 4) begin
      fails++;
      $display("FAIL abort_en_cycles: got %0d required 4", en_cnt);
    end
  endtask

  task automatic test_mismatch();
    bit ok;
    skip_req = 1'b1;
    issue(32'd10, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL skip_accept: got no handshake required accept"); end
    for (int c = 1; c <= 13; c++) begin
      if (c > 1) @(negedge clk);
      tests++;
      if (gc_if.done !== (c == 12)) begin
        fails++;
        $display("FAIL skip_done_cycle%0d: got done=%b required %b", c, gc_if.done, c == 12);
      end
      if (c == 12) begin
        tests++;
        if ({gc_if.q, gc_if.mismatch, gc_if.aborted} !== {32'd9, 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL skip_result: got q=%0d mis=%b abt=%b required q=9 mis=1 abt=0",
                   gc_if.q, gc_if.mismatch, gc_if.aborted);
        end
      end
    end
    skip_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit         ok;
    logic [2:0] exp_v;
    issue(32'd2, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL b2b_accept: got no handshake required accept"); end
    gc_if.cmd_valid = 1'b1;
    gc_if.cmd_len   = 32'd3;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) @(negedge clk);
      exp_v = {c == 1 || c == 6, c == 2 || c == 3 || (c >= 7 && c <= 9), c == 4 || c == 10};
      tests++;
      if ({gc_if.cnt_clr, gc_if.cnt_en, gc_if.done} !== exp_v) begin
        fails++;
        $display("FAIL b2b_cycle%0d: got clr,en,done=%b required %b", c,
                 {gc_if.cnt_clr, gc_if.cnt_en, gc_if.done}, exp_v);
      end
      if (c == 4 || c == 10) begin
        tests++;
        if ({gc_if.q, gc_if.mismatch, gc_if.aborted} !== {(c == 4) ? 32'd2 : 32'd3, 1'b0, 1'b0}) begin
          fails++;
          $display("FAIL b2b_result%0d: got q=%0d mis=%b abt=%b required q=%0d mis=0 abt=0", c,
                   gc_if.q, gc_if.mismatch, gc_if.aborted, (c == 4) ? 2 : 3);
        end
      end
      if (c == 4) gc_if.abort = 1'b1;
      if (c == 6) begin
        gc_if.abort     = 1'b0;
        gc_if.cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    issue(32'd20, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL areset_accept: got no handshake required accept"); end
    repeat (3) @(negedge clk);
    tests++;
    if ({gc_if.cnt_en, gc_if.busy} !== 2'b11) begin
      fails++;
      $display("FAIL areset_pre: got en,busy=%b required 11", {gc_if.cnt_en, gc_if.busy});
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({gc_if.cnt_en, gc_if.busy, gc_if.cmd_ready} !== 3'b001) begin
      fails++;
      $display("FAIL areset_instant: got en,busy,rdy=%b required 001",
               {gc_if.cnt_en, gc_if.busy, gc_if.cmd_ready});
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if ({gc_if.cnt_en, gc_if.busy, gc_if.cmd_ready} !== 3'b001) begin
      fails++;
      $display("FAIL areset_after: got en,busy,rdy=%b required 001",
               {gc_if.cnt_en, gc_if.busy, gc_if.cmd_ready});
    end
  endtask

`ifdef GCTRL_IDLE_GATE_EN
  task automatic test_idle_gate();
    bit         ok;
    logic [4:0] exp_v;
    issue(32'd1, ok);
    tests++;
    if (!ok) begin fails++; $display("FAIL gate_accept: got no handshake required accept"); end
    for (int c = 1; c <= 21; c++) begin
      if (c > 1) @(negedge clk);
      exp_v = {c != 12, (c >= 4 && c <= 11) || c == 15 || c == 21,
               c == 1 || c == 16, c == 2 || (c >= 17 && c <= 19), c == 3 || c == 20};
      tests++;
      if ({gc_if.gclk_en, gc_if.cmd_ready, gc_if.cnt_clr, gc_if.cnt_en, gc_if.done} !== exp_v) begin
        fails++;
        $display("FAIL gate_cycle%0d: got gclk,rdy,clr,en,done=%b required %b", c,
                 {gc_if.gclk_en, gc_if.cmd_ready, gc_if.cnt_clr, gc_if.cnt_en, gc_if.done}, exp_v);
      end
      if (c == 20) begin
        tests++;
        if ({gc_if.q, gc_if.mismatch} !== {32'd3, 1'b0}) begin
          fails++;
          $display("FAIL gate_result: got q=%0d mis=%b required q=3 mis=0", gc_if.q, gc_if.mismatch);
        end
      end
      if (c == 12) begin
        gc_if.cmd_valid = 1'b1;
        gc_if.cmd_len   = 32'd3;
      end
      if (c == 16) gc_if.cmd_valid = 1'b0;
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_run_len5();
    test_zero_len();
    test_abort();
    test_mismatch();
    test_back_to_back();
    test_async_reset();
`ifdef GCTRL_IDLE_GATE_EN
    test_idle_gate();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running required completion by 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
